// File: rtl/bcd_disp_pkg.sv
// Shared constants, FSM encoding and segment tables for the six-digit BCD display controller.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_e;

    // Active-low g..a codes for digits 9 (left) down to 0 (right).
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [3:0] add3_if_ge5(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational BCD nibble to active-low 7-segment decoder with blank and dash overrides.
module seg7_digit_dec
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (dash_i) begin
            seg_o = SEG_DASH;
        end else if (!blank_i && nibble_i <= 4'd9) begin
            seg_o = SEG_DIGITS[nibble_i];
        end
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Serial double-dabble converter driving six registered 7-segment digits with
// leading-zero blanking and overflow dashes.
module bcd_display_ctrl
    import bcd_disp_pkg::*;
#(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned NDIG  = 6
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_blank,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             done,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5
);

    localparam int unsigned BcdW   = 4 * NDIG;
    localparam int unsigned CntW   = $clog2(WIDTH + 1);
    localparam int unsigned MaxVal = 10 ** NDIG - 1;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] bin_q;
    logic [BcdW-1:0]  bcd_q;
    logic             ovf_q;
    logic             blank_q;
    logic             ready_q;
    logic             load_q;
    logic             done_q;
    logic [6:0]       hex_q   [NDIG];

    logic [BcdW-1:0]  bcd_adj;
    logic [NDIG-1:0]  blank_dig;
    logic [6:0]       seg_dec [NDIG];

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            bcd_adj[4*i +: 4] = add3_if_ge5(bcd_q[4*i +: 4]);
        end
    end

    // A digit is blanked when it and every digit above it are zero; HEX0 always shows.
    always_comb begin
        logic above_zero;
        above_zero = 1'b1;
        blank_dig  = '0;
        for (int i = int'(NDIG) - 1; i >= 0; i--) begin
            above_zero   = above_zero && (bcd_q[4*i +: 4] == 4'd0);
            blank_dig[i] = blank_q && above_zero && (i != 0);
        end
    end

    for (genvar g = 0; g < int'(NDIG); g++) begin : gen_dec
        seg7_digit_dec u_dec (
            .nibble_i (bcd_q[4*g +: 4]),
            .blank_i  (blank_dig[g]),
            .dash_i   (ovf_q),
            .seg_o    (seg_dec[g])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            blank_q <= 1'b0;
            ready_q <= 1'b1;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            hex_q   <= '{default: SEG_BLANK};
        end else begin
            load_q <= 1'b0;
            done_q <= load_q;
            // Outputs update one edge after LOAD; a transfer on that same edge sees the old result.
            if (load_q) begin
                hex_q <= seg_dec;
            end
            case (state_q)
                IDLE: begin
                    if (in_valid && ready_q) begin
                        bin_q   <= in_data;
                        blank_q <= in_blank;
                        bcd_q   <= '0;
                        cnt_q   <= CntW'(WIDTH);
                        ovf_q   <= (32'(in_data) > MaxVal);
                        ready_q <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj[BcdW-2:0], bin_q, 1'b0};
                    cnt_q          <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    load_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = ready_q;
    assign done     = done_q;
    assign HEX0     = hex_q[0];
    assign HEX1     = hex_q[1];
    assign HEX2     = hex_q[2];
    assign HEX3     = hex_q[3];
    assign HEX4     = hex_q[4];
    assign HEX5     = hex_q[5];

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Scoreboard bench for bcd_display_ctrl: expected displays are queued at each transfer and
// checked by an independent monitor whenever done pulses.
module tb_bcd_display_ctrl;

    localparam int unsigned W       = 20;
    localparam int unsigned LATENCY = 22;
    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
    localparam logic [6:0]  DIG [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic         CLOCK_50 = 1'b0;
    logic         RESET_N  = 1'b0;
    logic [W-1:0] in_data;
    logic         in_blank;
    logic         in_valid;
    logic         in_ready;
    logic         done;
    logic [6:0]   HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [41:0]  hex_all;

    typedef struct {
        logic [41:0] hex;
        int          due;
        int unsigned val;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [41:0] last_hex;

    bcd_display_ctrl #(
        .WIDTH (W),
        .NDIG  (6)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .in_data  (in_data),
        .in_blank (in_blank),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .done     (done),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5)
    );

    assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Decimal digits straight from the value; leading digit i is blank when value < 10^i.
    function automatic logic [41:0] model(input int unsigned v, input bit b);
        logic [41:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int i = 0; i < 6; i++) begin
            if (v > 999999)            r[i*7 +: 7] = 7'b0111111;
            else if (b && i > 0 && v < p) r[i*7 +: 7] = 7'b1111111;
            else                       r[i*7 +: 7] = DIG[int'((v / p) % 10)];
            p = p * 10;
        end
        return r;
    endfunction

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge CLOCK_50) begin
        exp_t e;
        if (!RESET_N) begin
            sb.delete();
            last_hex = ALL_BLANK;
        end else if (done) begin
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                e = sb.pop_front();
                check($sformatf("hex_value_%0d", e.val), 64'(hex_all), 64'(e.hex));
                check($sformatf("done_cycle_%0d", e.val), 64'(cyc), 64'(e.due));
            end
            last_hex = hex_all;
        end else begin
            if (hex_all !== last_hex) begin
                miscompares++;
                $display("FAIL hex_stable: got %0h without done, expected %0h", hex_all, last_hex);
                last_hex = hex_all;
            end
            if (sb.size() != 0 && cyc > sb[0].due) begin
                miscompares++;
                $display("FAIL done_timeout: value %0d got no done by cycle %0d, expected at %0d",
                         sb[0].val, cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    // Called in the low clock phase; returns in the low phase after in_ready has come back.
    task automatic send(input int unsigned v, input bit b);
        int   guard;
        exp_t e;
        in_data  = W'(v);
        in_blank = b;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            @(negedge CLOCK_50);
            guard++;
        end
        if (!in_ready) begin
            miscompares++;
            $display("FAIL ready_timeout: got in_ready=0 for 100 cycles, expected 1");
            in_valid = 1'b0;
            return;
        end
        e.hex = model(v, b);
        e.val = v;
        e.due = cyc + 1 + int'(LATENCY);
        sb.push_back(e);
        @(posedge CLOCK_50);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_blank = 1'($urandom);
        repeat (21) @(negedge CLOCK_50);
        check("ready_low_busy", 64'(in_ready), 64'(0));
        @(negedge CLOCK_50);
        check("ready_high_after", 64'(in_ready), 64'(1));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge CLOCK_50);
            guard++;
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending results, expected 0", sb.size());
        end
    endtask

    initial begin
        int   prev_t;
        int   t;
        int   guard;
        exp_t e;
        int unsigned v;

        in_data  = '0;
        in_blank = 1'b0;
        in_valid = 1'b0;
        prev_t   = 0;
        repeat (3) @(negedge CLOCK_50);
        check("reset_hex", 64'(hex_all), 64'(ALL_BLANK));
        check("reset_ready", 64'(in_ready), 64'(1));
        check("reset_done", 64'(done), 64'(0));
        RESET_N = 1'b1;
        @(negedge CLOCK_50);

        send(123456, 1'b1);
        send(0, 1'b1);
        send(42, 1'b0);
        send(1000000, 1'b0);
        send(1048575, 1'b1);
        send(999999, 1'b1);
        send(100000, 1'b1);
        send(5, 1'b0);
        drain();

        // in_valid held high across three values; junk data while busy must be ignored.
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data  = W'(7 + k);
            in_blank = 1'b0;
            guard    = 0;
            while (!in_ready && guard < 100) begin
                @(negedge CLOCK_50);
                guard++;
            end
            t = cyc + 1;
            if (k > 0) check("b2b_spacing", 64'(t - prev_t), 64'(LATENCY));
            prev_t = t;
            e.hex  = model(7 + k, 1'b0);
            e.val  = 7 + k;
            e.due  = t + int'(LATENCY);
            sb.push_back(e);
            @(posedge CLOCK_50);
            #1;
            in_data = W'(12345 + k);
            repeat (21) @(negedge CLOCK_50);
            check("b2b_ready_low", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        drain();

        // Reset ten cycles into a conversion.
        in_data  = W'(555555);
        in_blank = 1'b1;
        in_valid = 1'b1;
        e.hex    = model(555555, 1'b1);
        e.val    = 555555;
        e.due    = cyc + 1 + int'(LATENCY);
        sb.push_back(e);
        @(posedge CLOCK_50);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        #2;
        RESET_N = 1'b0;
        #1;
        check("midreset_hex", 64'(hex_all), 64'(ALL_BLANK));
        check("midreset_done", 64'(done), 64'(0));
        check("midreset_ready", 64'(in_ready), 64'(1));
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        send(9, 1'b1);
        drain();

        for (int n = 0; n < 30; n++) begin
            v = $urandom_range(1048575, 0);
            if ($urandom_range(3, 0) == 0) v = $urandom_range(999, 0);
            send(v, 1'($urandom_range(1, 0)));
            repeat ($urandom_range(3, 0)) @(negedge CLOCK_50);
        end
        drain();
        repeat (3) @(negedge CLOCK_50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
